// File: rtl/ttm4_seq_ctrl.sv
// TTM4 instruction sequencer: fetch/decode/exec/next cycle that drives the register,
// OUT and PC strobes, the ALU source select and immediate, and owns the carry flag.
module ttm4_seq_ctrl #(
  parameter int unsigned IMM_W = 4,
  parameter int unsigned OPC_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   run_i,
  input  logic [OPC_W+IMM_W-1:0] instr_i,
  input  logic                   alu_carry_i,
  output logic [1:0]             sel_o,
  output logic [IMM_W-1:0]       imm_o,
  output logic                   na_st_o,
  output logic                   nb_st_o,
  output logic                   nout_st_o,
  output logic                   npc_ld_o,
  output logic                   pc_inc_o,
  output logic                   carry_o,
  output logic                   busy_o
);

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam logic [OPC_W-1:0] OP_ADD_A   = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_MOV_A_B = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_IN_A    = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_MOV_A_I = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OP_MOV_B_A = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_ADD_B   = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_IN_B    = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OP_MOV_B_I = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_OUT_B   = OPC_W'(4'h9);
  localparam logic [OPC_W-1:0] OP_OUT_I   = OPC_W'(4'hB);
  localparam logic [OPC_W-1:0] OP_JNC     = OPC_W'(4'hE);
  localparam logic [OPC_W-1:0] OP_JMP     = OPC_W'(4'hF);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_NEXT   = 3'd4
  } state_e;

  state_e             state_q;
  logic [OPC_W-1:0]   opc_q;
  logic [IMM_W-1:0]   imm_q;
  logic [1:0]         sel_q;
  logic               na_st_q, nb_st_q, nout_st_q, npc_ld_q, pc_inc_q;
  logic               carry_q, busy_q;

  logic [OPC_W-1:0]   fetch_opc_c;
  logic [IMM_W-1:0]   fetch_imm_c;
  logic [1:0]         fetch_sel_c;
  logic               wr_a_c, wr_b_c, wr_out_c, c_alu_c, c_keep_c, jump_c;

  // Source select and immediate for the word being fetched; MOV A,B / MOV B,A add zero.
  always_comb begin
    fetch_opc_c = instr_i[OPC_W+IMM_W-1 -: OPC_W];
    fetch_imm_c = instr_i[IMM_W-1:0];
    fetch_sel_c = SEL_ZERO;
    case (fetch_opc_c)
      OP_ADD_A:             fetch_sel_c = SEL_A;
      OP_MOV_B_A: begin
        fetch_sel_c = SEL_A;
        fetch_imm_c = '0;
      end
      OP_MOV_A_B: begin
        fetch_sel_c = SEL_B;
        fetch_imm_c = '0;
      end
      OP_ADD_B, OP_OUT_B:   fetch_sel_c = SEL_B;
      OP_IN_A, OP_IN_B:     fetch_sel_c = SEL_IN;
      default:              fetch_sel_c = SEL_ZERO;
    endcase
  end

  // Execute-phase decode of the latched opcode; JNC looks at the carry as it enters S_NEXT.
  always_comb begin
    wr_a_c   = 1'b0;
    wr_b_c   = 1'b0;
    wr_out_c = 1'b0;
    c_alu_c  = 1'b0;
    c_keep_c = 1'b0;
    jump_c   = 1'b0;
    case (opc_q)
      OP_ADD_A: begin
        wr_a_c  = 1'b1;
        c_alu_c = 1'b1;
      end
      OP_MOV_A_B, OP_IN_A, OP_MOV_A_I: wr_a_c = 1'b1;
      OP_ADD_B: begin
        wr_b_c  = 1'b1;
        c_alu_c = 1'b1;
      end
      OP_MOV_B_A, OP_IN_B, OP_MOV_B_I: wr_b_c = 1'b1;
      OP_OUT_B, OP_OUT_I:              wr_out_c = 1'b1;
      OP_JMP: begin
        c_keep_c = 1'b1;
        jump_c   = 1'b1;
      end
      OP_JNC: begin
        c_keep_c = 1'b1;
        jump_c   = ~carry_q;
      end
      default: ;
    endcase
  end

  // Sequencer; every output is registered so it reflects the state it belongs to.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      opc_q     <= '0;
      imm_q     <= '0;
      sel_q     <= SEL_ZERO;
      na_st_q   <= 1'b1;
      nb_st_q   <= 1'b1;
      nout_st_q <= 1'b1;
      npc_ld_q  <= 1'b1;
      pc_inc_q  <= 1'b0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      na_st_q   <= 1'b1;
      nb_st_q   <= 1'b1;
      nout_st_q <= 1'b1;
      npc_ld_q  <= 1'b1;
      pc_inc_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (run_i) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          opc_q   <= fetch_opc_c;
          imm_q   <= fetch_imm_c;
          sel_q   <= fetch_sel_c;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          na_st_q   <= ~wr_a_c;
          nb_st_q   <= ~wr_b_c;
          nout_st_q <= ~wr_out_c;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          if (c_alu_c) begin
            carry_q <= alu_carry_i;
          end else if (!c_keep_c) begin
            carry_q <= 1'b0;
          end
          if (jump_c) begin
            npc_ld_q <= 1'b0;
          end else begin
            pc_inc_q <= 1'b1;
          end
          state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (run_i) begin
            state_q <= S_FETCH;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_o     = sel_q;
  assign imm_o     = imm_q;
  assign na_st_o   = na_st_q;
  assign nb_st_o   = nb_st_q;
  assign nout_st_o = nout_st_q;
  assign npc_ld_o  = npc_ld_q;
  assign pc_inc_o  = pc_inc_q;
  assign carry_o   = carry_q;
  assign busy_o    = busy_q;

endmodule
